ad_jesd_rx_align: RTL and testbench

AD_JESD_RX_ALIGN -- requirements
Module: ad_jesd_rx_align

---
 rtl/ad_jesd_rx_align.sv | 136 +++++++++++++
 tb/tb_ad_jesd_rx_align.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad_jesd_rx_align.sv
// JESD204 receive frame aligner: locks onto a common SOF byte offset, realigns
// the four 32-bit lanes across beat boundaries and unpacks two 4-sample converters.
module ad_jesd_rx_align #(
  parameter int unsigned ERR_THRESHOLD = 3
) (
  input  logic         rx_clk,
  input  logic         rx_rstn,
  input  logic [127:0] rx_data,
  input  logic         rx_valid,
  input  logic [3:0]   rx_sof,
  output logic         rx_ready,
  output logic         adc_valid,
  output logic [63:0]  adc_data_0,
  output logic [63:0]  adc_data_1,
  output logic         adc_status,
  output logic [7:0]   adc_relock_cnt
);

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  localparam logic [4:0] LP_THR = 5'(ERR_THRESHOLD);

  state_t       r_state;
  logic [127:0] r_prev;
  logic [1:0]   r_k;
  logic [3:0]   r_err;
  logic         r_adc_valid;
  logic         r_status;
  logic [63:0]  r_data_0;
  logic [63:0]  r_data_1;
  logic [7:0]   r_relock;

  logic         w_sof_onehot;
  logic [1:0]   w_sof_idx;
  logic [3:0]   w_k_onehot;
  logic [4:0]   w_err_inc;
  logic [127:0] w_aligned;
  logic [127:0] w_samples;
  logic [7:0]   w_relock_inc;

  assign rx_ready       = rx_rstn;
  assign adc_valid      = r_adc_valid;
  assign adc_data_0     = r_data_0;
  assign adc_data_1     = r_data_1;
  assign adc_status     = r_status;
  assign adc_relock_cnt = r_relock;

  assign w_sof_onehot = $onehot(rx_sof);
  assign w_k_onehot   = 4'b0001 << r_k;
  assign w_err_inc    = {1'b0, r_err} + 5'd1;
  assign w_relock_inc = (r_relock == 8'hFF) ? r_relock : r_relock + 8'd1;

  always_comb begin
    w_sof_idx = 2'd0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (rx_sof[i]) w_sof_idx = 2'(i);
    end
  end

  // Aligned lane word = bytes K..K+3 of {current, previous}, previous in the low half
  always_comb begin
    w_aligned = '0;
    for (int unsigned l = 0; l < 4; l++) begin
      w_aligned[32*l +: 32] = 32'({rx_data[32*l +: 32], r_prev[32*l +: 32]} >> {r_k, 3'b000});
    end
  end

  // Each lane carries two samples; the first-received octet of a pair is the MSB
  always_comb begin
    w_samples = '0;
    for (int unsigned l = 0; l < 4; l++) begin
      w_samples[32*l +: 32] = {w_aligned[32*l+16 +: 8], w_aligned[32*l+24 +: 8],
                               w_aligned[32*l    +: 8], w_aligned[32*l+8  +: 8]};
    end
  end

  always_ff @(posedge rx_clk or negedge rx_rstn) begin
    if (!rx_rstn) begin
      r_state     <= ST_SEARCH;
      r_prev      <= '0;
      r_k         <= '0;
      r_err       <= '0;
      r_adc_valid <= 1'b0;
      r_status    <= 1'b0;
      r_data_0    <= '0;
      r_data_1    <= '0;
      r_relock    <= '0;
    end else begin
      r_adc_valid <= 1'b0;
      if (rx_valid) begin
        r_prev <= rx_data;
        if (r_state == ST_LOCKED) begin
          r_adc_valid <= 1'b1;
          r_data_0    <= w_samples[63:0];
          r_data_1    <= w_samples[127:64];
        end
      end
      case (r_state)
        ST_SEARCH: begin
          if (rx_valid && w_sof_onehot) begin
            r_state  <= ST_LOCKED;
            r_status <= 1'b1;
            r_k      <= w_sof_idx;
            r_err    <= '0;
          end
        end
        ST_LOCKED: begin
          if (!rx_valid) begin
            r_state  <= ST_SEARCH;
            r_status <= 1'b0;
            r_relock <= w_relock_inc;
          end else if (rx_sof != 4'b0000) begin
            if (rx_sof == w_k_onehot) begin
              r_err <= '0;
            end else if (w_err_inc >= LP_THR) begin
              r_state  <= ST_SEARCH;
              r_status <= 1'b0;
              r_err    <= '0;
              r_relock <= w_relock_inc;
            end else begin
              r_err <= w_err_inc[3:0];
            end
          end
        end
        default: begin
          r_state  <= ST_SEARCH;
          r_status <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ad_jesd_rx_align.sv
// Scoreboard bench for ad_jesd_rx_align: byte-level reference model feeds
// per-cycle and per-output queues that a separate monitor drains.
module tb_ad_jesd_rx_align;

  localparam int unsigned THR = 3;

  logic         rx_clk = 1'b0;
  logic         rx_rstn = 1'b0;
  logic [127:0] rx_data = '0;
  logic         rx_valid = 1'b0;
  logic [3:0]   rx_sof = '0;
  logic         rx_ready;
  logic         adc_valid;
  logic [63:0]  adc_data_0;
  logic [63:0]  adc_data_1;
  logic         adc_status;
  logic [7:0]   adc_relock_cnt;

  ad_jesd_rx_align #(.ERR_THRESHOLD(THR)) dut (
    .rx_clk         (rx_clk),
    .rx_rstn        (rx_rstn),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_sof         (rx_sof),
    .rx_ready       (rx_ready),
    .adc_valid      (adc_valid),
    .adc_data_0     (adc_data_0),
    .adc_data_1     (adc_data_1),
    .adc_status     (adc_status),
    .adc_relock_cnt (adc_relock_cnt)
  );

  always #5 rx_clk = ~rx_clk;

  typedef struct {
    bit          v;
    bit          st;
    int unsigned rc;
    logic [63:0] d0;
    logic [63:0] d1;
  } cyc_t;

  cyc_t         cyc_q[$];
  logic [127:0] data_q[$];
  int           n_tests = 0;
  int           n_fail = 0;
  bit           in_reset = 1'b1;

  bit           m_locked;
  int unsigned  m_k, m_err, m_rc;
  logic [127:0] m_prev;
  logic [63:0]  m_d0, m_d1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] abyte(input logic [127:0] p, input logic [127:0] c,
                                       input int unsigned k, input int unsigned lane,
                                       input int unsigned i);
    int unsigned n;
    n = i + k;
    if (n < 4) return p[32*lane + 8*n +: 8];
    return c[32*lane + 8*(n-4) +: 8];
  endfunction

  task automatic model_reset();
    m_locked = 1'b0;
    m_k = 0; m_err = 0; m_rc = 0;
    m_prev = '0; m_d0 = '0; m_d1 = '0;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic beat(input bit v, input logic [3:0] sof, input logic [127:0] d);
    cyc_t        r;
    bit          ev;
    logic [15:0] s;
    int unsigned lane, b;
    ev = 1'b0;
    rx_valid = v; rx_sof = sof; rx_data = d;
    if (!v) begin
      if (m_locked) begin
        m_locked = 1'b0;
        if (m_rc < 255) m_rc++;
      end
    end else begin
      if (m_locked) begin
        ev = 1'b1;
        for (int unsigned c = 0; c < 2; c++) begin
          for (int unsigned j = 0; j < 4; j++) begin
            lane = 2*c + j/2;
            b    = 2*(j%2);
            s = {abyte(m_prev, d, m_k, lane, b), abyte(m_prev, d, m_k, lane, b+1)};
            if (c == 0) m_d0[16*j +: 16] = s;
            else        m_d1[16*j +: 16] = s;
          end
        end
      end
      if (!m_locked) begin
        if ($countones(sof) == 1) begin
          m_locked = 1'b1;
          m_err = 0;
          for (int unsigned k = 0; k < 4; k++) if (sof[k]) m_k = k;
        end
      end else if (sof != 4'b0000) begin
        if (sof == 4'(1 << m_k)) m_err = 0;
        else begin
          m_err++;
          if (m_err >= THR) begin
            m_locked = 1'b0;
            if (m_rc < 255) m_rc++;
          end
        end
      end
      m_prev = d;
    end
    r.v = ev; r.st = m_locked; r.rc = m_rc; r.d0 = m_d0; r.d1 = m_d1;
    cyc_q.push_back(r);
    if (ev) data_q.push_back({m_d1, m_d0});
    @(negedge rx_clk);
  endtask

  // Called at a negedge; asserts reset between edges and checks outputs immediately
  task automatic do_reset();
    #2;
    rx_rstn = 1'b0;
    in_reset = 1'b1;
    rx_valid = 1'b0;
    #1;
    chk("rst_adc_valid", adc_valid, 0);
    chk("rst_adc_status", adc_status, 0);
    chk("rst_relock_cnt", adc_relock_cnt, 0);
    chk("rst_adc_data", {adc_data_1, adc_data_0}, 0);
    chk("rst_rx_ready", rx_ready, 0);
    cyc_q.delete();
    data_q.delete();
    model_reset();
    repeat (2) @(negedge rx_clk);
    rx_rstn = 1'b1;
    in_reset = 1'b0;
  endtask

  always begin
    cyc_t r;
    logic [127:0] e;
    @(posedge rx_clk);
    #1;
    if (!in_reset && cyc_q.size() > 0) begin
      r = cyc_q.pop_front();
      chk("adc_valid", adc_valid, r.v);
      chk("adc_status", adc_status, r.st);
      chk("relock_cnt", adc_relock_cnt, r.rc);
      chk("held_data", {adc_data_1, adc_data_0}, {r.d1, r.d0});
    end
    if (!in_reset && adc_valid === 1'b1) begin
      if (data_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: got adc_valid=1 expected no pending sample set");
      end else begin
        e = data_q.pop_front();
        chk("adc_data", {adc_data_1, adc_data_0}, e);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] d;
    logic [3:0]   sof;
    int unsigned  rc0, r;
    model_reset();
    repeat (3) @(negedge rx_clk);
    chk("reset_adc_valid", adc_valid, 0);
    chk("reset_adc_status", adc_status, 0);
    chk("reset_relock_cnt", adc_relock_cnt, 0);
    chk("reset_adc_data", {adc_data_1, adc_data_0}, 0);
    chk("reset_rx_ready", rx_ready, 0);
    rx_rstn = 1'b1;
    in_reset = 1'b0;

    // Lock at K=0
    beat(1, 4'b0000, rnd128());
    chk("search_status", adc_status, 0);
    d = rnd128(); d[31:0] = 32'h78563412;
    beat(1, 4'b0001, d);
    chk("k0_locked", adc_status, 1);
    chk("k0_no_valid_yet", adc_valid, 0);
    beat(1, 4'b0000, rnd128());
    chk("k0_first_valid", adc_valid, 1);
    chk("k0_samples", adc_data_0[31:0], 32'h56781234);
    chk("rx_ready_high", rx_ready, 1);

    // Valid drop, then relock at K=2
    beat(0, 4'b0000, rnd128());
    chk("drop_status", adc_status, 0);
    chk("drop_valid", adc_valid, 0);
    beat(1, 4'b0000, rnd128());
    chk("drop_no_output", adc_valid, 0);
    d = rnd128(); d[31:0] = 32'h2211BBAA;
    beat(1, 4'b0100, d);
    chk("k2_lock_no_output", adc_valid, 0);
    d = rnd128(); d[31:0] = 32'hDDCC4433;
    beat(1, 4'b0000, d);
    chk("k2_valid", adc_valid, 1);
    chk("k2_samples", adc_data_0[31:0], 32'h33441122);

    // Mismatch threshold
    beat(0, 4'b0000, rnd128());
    beat(1, 4'b0001, rnd128());
    rc0 = m_rc;
    beat(1, 4'b0100, rnd128());
    beat(1, 4'b0100, rnd128());
    chk("two_mismatch_locked", adc_status, 1);
    beat(1, 4'b0100, rnd128());
    chk("third_mismatch_search", adc_status, 0);
    chk("relock_incr", adc_relock_cnt, rc0 + 1);
    beat(1, 4'b0001, rnd128());
    beat(1, 4'b0100, rnd128());
    beat(1, 4'b0100, rnd128());
    beat(1, 4'b0001, rnd128());
    chk("match_clears", adc_status, 1);
    beat(1, 4'b0000, rnd128());
    beat(1, 4'b0110, rnd128());
    beat(1, 4'b0010, rnd128());
    chk("cleared_counter_locked", adc_status, 1);

    // Async reset mid-stream, then lock at K=3
    do_reset();
    d = rnd128(); d[31:0] = 32'h44332211;
    beat(1, 4'b1000, d);
    chk("k3_locked", adc_status, 1);
    d = rnd128(); d[31:0] = 32'h88776655;
    beat(1, 4'b0000, d);
    chk("k3_valid", adc_valid, 1);
    chk("k3_samples", adc_data_0[31:0], 32'h66774455);

    // Randomized traffic
    for (int unsigned i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      sof = 4'b0000;
      else if (r < 9) sof = 4'b0001 << $urandom_range(0, 3);
      else            sof = 4'($urandom);
      beat(($urandom_range(0, 19) != 0), sof, rnd128());
    end

    // Relock counter saturation
    for (int unsigned i = 0; i < 260; i++) begin
      beat(1, 4'b0001, rnd128());
      beat(0, 4'b0000, rnd128());
    end
    chk("relock_saturated", adc_relock_cnt, 255);

    beat(1, 4'b0000, rnd128());
    chk("queue_drained", data_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
